apb_master: RTL and testbench
=============================

APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning the command and APB address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning the command, response and APB data width.
REQ-003 The block SHALL have parameter TIMEOUT, default 16, meaning the maximum number of ACCESS cycles without pready before abort; 0 disables the timeout.
REQ-004 The block SHALL have port pclk  input  1  clock; all logic is on its rising edge; this is the only clock.
REQ-005 The block SHALL have port presetn  input  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have port cmd_valid  input  1  command request.
REQ-007 The block SHALL have port cmd_ready  output  1  command accepted when high together with cmd_valid.
REQ-008 The block SHALL have the following command fields: cmd_write  input  1  1=write, 0=read; cmd_addr  input  ADDR_W  target address; cmd_wdata  input  DATA_W  write data.
REQ-009 The block SHALL have the following response ports: rsp_valid  output  1  response available; rsp_ready  input  1  response consumed; rsp_rdata  output  DATA_W  read data; rsp_err  output  1  pslverr or timeout; rsp_timeout  output  1  timeout abort.
REQ-010 The block SHALL have the following APB request ports: paddr  output  ADDR_W; pwdata  output  DATA_W; pwrite  output  1; psel  output  1; penable  output  1.
REQ-011 The block SHALL have the following APB completion ports: pready  input  1; pslverr  input  1; prdata  input  DATA_W.

Function
REQ-012 The FSM SHALL have the states IDLE, SETUP, ACCESS and RESP; all outputs except cmd_ready SHALL be registered.
REQ-013 cmd_ready SHALL equal (state==IDLE) AND presetn.
REQ-014 In IDLE, when cmd_valid and cmd_ready are both high at an edge, the block SHALL latch cmd_addr, cmd_write and cmd_wdata, and move to SETUP with psel=1, penable=0.
REQ-015 pwdata SHALL carry the latched cmd_wdata for writes and 0 for reads.
REQ-016 SETUP SHALL last exactly one cycle and then move to ACCESS with penable=1.
REQ-017 pready SHALL be ignored in SETUP.
REQ-018 paddr, pwrite, pwdata and psel SHALL stay stable from SETUP until the transfer ends.
REQ-019 In ACCESS, when pready=1 the block SHALL capture rsp_rdata=prdata for reads (0 for writes), rsp_err=pslverr and rsp_timeout=0.
REQ-020 On that same pready=1 edge the block SHALL drive psel=0, penable=0 and rsp_valid=1, and move to RESP.
REQ-021 pslverr and prdata SHALL be sampled only when in ACCESS with pready=1.
REQ-022 The wait counter SHALL be cleared on entry to ACCESS and SHALL increment on each ACCESS cycle with pready=0.
REQ-023 When TIMEOUT>0 and pready=0 with the counter at TIMEOUT-1, the block SHALL abort: psel=0, penable=0, rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0, state RESP. Exactly TIMEOUT ACCESS cycles elapse before abort.
REQ-024 The wait counter SHALL be wide enough to hold TIMEOUT without wrap-around; when TIMEOUT=0 the counter SHALL saturate and never abort.
REQ-025 In RESP, rsp_valid, rsp_rdata, rsp_err and rsp_timeout SHALL hold stable until rsp_ready=1 at an edge.
REQ-026 On that rsp_ready=1 edge the block SHALL clear rsp_valid and move to IDLE; other rsp fields SHALL hold their values.
REQ-027 Minimum latency SHALL be: command accepted at edge N; psel=1 from edge N; penable=1 from edge N+1; with pready=1 in the first ACCESS cycle, rsp_valid=1 from edge N+2.
REQ-028 Between transfers psel SHALL be low for at least two cycles (RESP plus IDLE), with no back-to-back SETUP.

Reset
REQ-029 While presetn=0, state SHALL be IDLE and psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err, rsp_timeout and the wait counter SHALL be 0.
REQ-030 Reset asserted mid-transfer (SETUP, ACCESS or RESP) SHALL discard the transfer immediately, with no response and no further APB activity.

Verification
REQ-031 Write: addr 0x4, wdata 0x12345678, pready=1 in the first ACCESS cycle -> psel for 2 cycles, pwdata 0x12345678 stable, rsp_valid at N+2, rsp_err=0, rsp_rdata=0.
REQ-032 Read: addr 0x8, pready low for 2 ACCESS cycles, then prdata 0xFACE5678 -> penable high 3 cycles, rsp_rdata=0xFACE5678, rsp_err=0.
REQ-033 Error: read addr 0xC, pslverr=1 with pready -> rsp_err=1, rsp_timeout=0.
REQ-034 Timeout: TIMEOUT=16, pready held 0 -> psel/penable drop after 16 ACCESS cycles, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
REQ-035 Backpressure: rsp_ready low for 5 cycles with cmd_valid held high -> rsp fields stable, cmd_ready=0, psel=0; next SETUP starts 2 cycles after the rsp handshake.
REQ-036 Reset mid-ACCESS: presetn pulled low -> all outputs 0 immediately, no rsp_valid, cmd_ready=1 after release.

Source files
------------

// File: rtl/apb_master.sv
// APB requester: turns one command into a single APB transfer and returns a
// response (read data, slave error, timeout) through a valid/ready handshake.
module apb_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  output logic              pwrite,
  output logic              psel,
  output logic              penable,
  input  logic              pready,
  input  logic              pslverr,
  input  logic [DATA_W-1:0] prdata
);

  // state  | meaning
  // IDLE   | waiting for a command, cmd_ready high
  // SETUP  | psel high, penable low, one cycle
  // ACCESS | psel and penable high, waiting for pready or timeout
  // RESP   | response held until rsp_ready
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic                pwrite_q, pwrite_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic                rsp_timeout_q, rsp_timeout_d;
  logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q       <= ST_IDLE;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pwrite_q      <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      wait_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      pwrite_q      <= pwrite_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      wait_cnt_q    <= wait_cnt_d;
    end
  end

  // Only unregistered output; gated by presetn so nothing is accepted in reset.
  assign cmd_ready = (state_q == ST_IDLE) && presetn;

  always_comb begin
    state_d       = state_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    pwrite_d      = pwrite_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    wait_cnt_d    = wait_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          state_d   = ST_SETUP;
          paddr_d   = cmd_addr;
          pwrite_d  = cmd_write;
          pwdata_d  = cmd_write ? cmd_wdata : '0;
          psel_d    = 1'b1;
          penable_d = 1'b0;
        end
      end
      ST_SETUP: begin
        state_d    = ST_ACCESS;
        penable_d  = 1'b1;
        wait_cnt_d = '0;
      end
      ST_ACCESS: begin
        if (pready) begin
          state_d       = ST_RESP;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = pwrite_q ? '0 : prdata;
          rsp_err_d     = pslverr;
          rsp_timeout_d = 1'b0;
        end else if ((TIMEOUT > 0) && (wait_cnt_q == CNT_LAST)) begin
          state_d       = ST_RESP;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
        end else if (wait_cnt_q != CNT_MAX) begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign pwrite      = pwrite_q;
  assign psel        = psel_q;
  assign penable     = penable_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: directed and random transfers compared cycle by cycle
// against a transaction-level expectation of the APB waveform and response.
module tb_apb_master;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 16;

  logic          pclk = 1'b0;
  logic          presetn;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err, rsp_timeout;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic          pwrite, psel, penable;
  logic          pready, pslverr;
  logic [DW-1:0] prdata;

  int n_checks = 0;
  int n_fail   = 0;

  apb_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .pclk(pclk), .presetn(presetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite), .psel(psel), .penable(penable),
    .pready(pready), .pslverr(pslverr), .prdata(prdata)
  );

  always #5 pclk = ~pclk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic check_bus(input string ph, input logic e_sel, input logic e_en,
                           input logic [AW-1:0] e_addr, input logic e_wr,
                           input logic [DW-1:0] e_wd);
    check_val({ph, " psel"}, psel, e_sel);
    check_val({ph, " penable"}, penable, e_en);
    if (e_sel) begin
      check_val({ph, " paddr"}, paddr, e_addr);
      check_val({ph, " pwrite"}, pwrite, e_wr);
      check_val({ph, " pwdata"}, pwdata, e_wd);
    end
  endtask

  task automatic check_rsp(input string ph, input logic e_v, input logic [DW-1:0] e_rd,
                           input logic e_err, input logic e_to);
    check_val({ph, " rsp_valid"}, rsp_valid, e_v);
    check_val({ph, " rsp_rdata"}, rsp_rdata, e_rd);
    check_val({ph, " rsp_err"}, rsp_err, e_err);
    check_val({ph, " rsp_timeout"}, rsp_timeout, e_to);
  endtask

  // One transfer starting in an IDLE cycle (just after an edge). The slave
  // answers in ACCESS cycle index `wait_n`; if that is beyond TMO the transfer
  // must abort after exactly TMO ACCESS cycles. Response is held `bp` cycles.
  task automatic do_xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                         input int wait_n, input logic err, input logic [DW-1:0] rd, input int bp);
    logic [DW-1:0] e_wd;
    logic [DW-1:0] e_rd;
    logic          e_err, e_to;
    int            n_acc;
    e_wd  = wr ? wd : '0;
    e_to  = (wait_n >= TMO);
    e_err = e_to ? 1'b1 : err;
    e_rd  = (e_to || wr) ? '0 : rd;
    n_acc = e_to ? TMO : wait_n + 1;

    check_val("idle cmd_ready", cmd_ready, 1'b1);
    check_val("idle psel", psel, 1'b0);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
    pready = $urandom_range(0, 1); rsp_ready = $urandom_range(0, 1);
    tick();

    check_bus("setup", 1'b1, 1'b0, addr, wr, e_wd);
    check_val("setup rsp_valid", rsp_valid, 1'b0);
    check_val("setup cmd_ready", cmd_ready, 1'b0);
    // Keep a different command pending; it must not be taken mid-transfer.
    cmd_write = $urandom_range(0, 1); cmd_addr = $urandom; cmd_wdata = $urandom;
    pready = $urandom_range(0, 1); pslverr = $urandom_range(0, 1); prdata = $urandom;
    tick();

    for (int i = 0; i < n_acc; i++) begin
      check_bus("access", 1'b1, 1'b1, addr, wr, e_wd);
      check_val("access rsp_valid", rsp_valid, 1'b0);
      check_val("access cmd_ready", cmd_ready, 1'b0);
      if (i == wait_n) begin
        pready = 1'b1; pslverr = err; prdata = rd;
      end else begin
        pready = 1'b0; pslverr = $urandom_range(0, 1); prdata = $urandom;
      end
      rsp_ready = $urandom_range(0, 1);
      tick();
    end
    pready = 1'b0;

    for (int j = 0; j <= bp; j++) begin
      check_bus("resp", 1'b0, 1'b0, addr, wr, e_wd);
      check_rsp("resp", 1'b1, e_rd, e_err, e_to);
      check_val("resp cmd_ready", cmd_ready, 1'b0);
      rsp_ready = (j == bp);
      pslverr = $urandom_range(0, 1); prdata = $urandom;
      tick();
    end
    rsp_ready = 1'b0;
    check_rsp("done", 1'b0, e_rd, e_err, e_to);
    check_val("done psel", psel, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    presetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; pready = 1'b0; pslverr = 1'b0; prdata = '0;
    #12;
    check_val("rst cmd_ready", cmd_ready, 1'b0);
    check_bus("rst", 1'b0, 1'b0, '0, 1'b0, '0);
    check_val("rst paddr", paddr, '0);
    check_val("rst pwdata", pwdata, '0);
    check_val("rst pwrite", pwrite, 1'b0);
    check_rsp("rst", 1'b0, '0, 1'b0, 1'b0);
    @(negedge pclk) presetn = 1'b1;
    tick();

    do_xfer(1'b1, 32'h4, 32'h1234_5678, 0, 1'b0, 32'hDEAD_BEEF, 0);
    do_xfer(1'b0, 32'h8, 32'h1111_2222, 2, 1'b0, 32'hFACE_5678, 1);
    do_xfer(1'b0, 32'hC, 32'h0, 0, 1'b1, 32'h5555_AAAA, 0);
    do_xfer(1'b0, 32'h10, 32'h0, 1000, 1'b0, 32'h0, 0);
    do_xfer(1'b1, 32'h14, 32'hCAFE_0001, TMO - 1, 1'b0, 32'h0, 5);
    do_xfer(1'b0, 32'h18, 32'h0, 1, 1'b0, 32'h0BAD_F00D, 5);

    for (int k = 0; k < 40; k++) begin
      int wn;
      wn = ($urandom_range(0, 9) == 0) ? $urandom_range(TMO, TMO + 3) : $urandom_range(0, 5);
      do_xfer($urandom_range(0, 1), $urandom, $urandom, wn, $urandom_range(0, 1),
              $urandom, $urandom_range(0, 3));
    end

    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h20; cmd_wdata = 32'h7777_8888;
    tick();
    cmd_valid = 1'b0;
    tick();
    check_val("prerst penable", penable, 1'b1);
    #2 presetn = 1'b0;
    #1;
    check_bus("midrst", 1'b0, 1'b0, '0, 1'b0, '0);
    check_val("midrst paddr", paddr, '0);
    check_val("midrst pwdata", pwdata, '0);
    check_val("midrst pwrite", pwrite, 1'b0);
    check_rsp("midrst", 1'b0, '0, 1'b0, 1'b0);
    check_val("midrst cmd_ready", cmd_ready, 1'b0);
    pready = 1'b1;
    @(negedge pclk) presetn = 1'b1;
    tick();
    check_val("postrst cmd_ready", cmd_ready, 1'b1);
    check_val("postrst rsp_valid", rsp_valid, 1'b0);
    check_val("postrst psel", psel, 1'b0);
    pready = 1'b0;
    tick();
    check_val("postrst2 psel", psel, 1'b0);
    check_val("postrst2 rsp_valid", rsp_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
